// File: rtl/shift_rotate_pipe.sv
// Pipelined barrel shifter/rotator: one register stage per shift-amount bit.
// Each stage holds data, count, op and valid behind a valid/ready chain.
module shift_rotate_pipe #(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  input  logic [CW-1:0]    Cnt,
  input  logic [1:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             out_zero
);

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             en,
    input int               s
  );
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      unique case (op)
        2'b00:   r = (d << s) | (d >> (WIDTH - s));
        2'b01:   r = d << s;
        2'b10:   r = (d >> s) | (d << (WIDTH - s));
        default: r = $signed(d) >>> s;
      endcase
    end
    return r;
  endfunction

  logic [CW-1:0] vq;
  logic [CW-1:0] rdy;
  logic          zq;

  for (genvar k = 0; k < CW; k++) begin : stg
    logic             v;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    c;
    logic [1:0]       o;
    logic             sv;
    logic [WIDTH-1:0] sd;
    logic [CW-1:0]    sc;
    logic [1:0]       so;
    logic [WIDTH-1:0] nd;

    if (k == 0) begin : src
      assign sv = in_valid;
      assign sd = In;
      assign sc = Cnt;
      assign so = Op;
    end else begin : src
      assign sv = stg[k-1].v;
      assign sd = stg[k-1].d;
      assign sc = stg[k-1].c;
      assign so = stg[k-1].o;
    end

    assign nd     = step(sd, so, sc[k], 1 << k);
    assign vq[k]  = v;
    // accept when any stage from here down is empty, or the output drains
    assign rdy[k] = out_ready || !(&vq[CW-1:k]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        d <= '0;
        c <= '0;
        o <= '0;
      end else if (rdy[k]) begin
        v <= sv;
        if (sv) begin
          d <= nd;
          c <= sc;
          o <= so;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zq <= 1'b0;
    end else if (rdy[CW-1]) begin
      zq <= stg[CW-1].sv && (stg[CW-1].nd == '0);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = stg[CW-1].v;
  assign Out       = stg[CW-1].d;
  assign out_zero  = zq;

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Bench for shift_rotate_pipe: directed cases plus random stream
// against an arithmetic reference model.
module tb_shift_rotate_pipe;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [W-1:0]  In = '0;
  logic [CW-1:0] Cnt = '0;
  logic [1:0]    Op = '0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [W-1:0]  Out;
  logic          out_zero;

  shift_rotate_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .In(In), .Cnt(Cnt), .Op(Op),
    .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic lat_en = 0;

  logic [W-1:0] eq[$];
  int           tq[$];
  logic [W-1:0] obs[$];
  logic         obs_z[$];
  int           obs_t[$];
  logic         held_v = 0;
  logic [W-1:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] x,
                                         input logic [CW-1:0] c,
                                         input logic [1:0] op);
    logic [2*W-1:0] xx;
    logic [2*W-1:0] zx;
    int sx;
    xx = {x, x};
    zx = {{W{1'b0}}, x};
    sx = int'($signed(x));
    case (op)
      2'd0: begin xx = xx << c; return xx[2*W-1:W]; end
      2'd1: begin zx = zx << c; return zx[W-1:0]; end
      2'd2: begin xx = xx >> c; return xx[W-1:0]; end
      default: begin sx = sx >>> c; return sx[W-1:0]; end
    endcase
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    int t;
    if (!rst_n) begin
      eq.delete();
      tq.delete();
      held_v = 0;
    end else begin
      if (held_v) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(Out), 32'(held));
      end
      held_v = out_valid && !out_ready;
      held = Out;
      if (out_valid && out_ready) begin
        obs.push_back(Out);
        obs_z.push_back(out_zero);
        obs_t.push_back(cyc);
        if (eq.size() == 0) begin
          chk("spurious_out", 32'(eq.size()), 1);
        end else begin
          e = eq.pop_front();
          t = tq.pop_front();
          chk("data", 32'(Out), 32'(e));
          chk("zero", 32'(out_zero), 32'(e == '0));
          if (lat_en) chk("latency", 32'(cyc - t), CW);
        end
      end
      if (in_valid && in_ready) begin
        eq.push_back(model(In, Cnt, Op));
        tq.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [CW-1:0] c,
                      input logic [1:0] o, output int w);
    In = d;
    Cnt = c;
    Op = o;
    in_valid = 1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic wait_obs(input int n);
    int w = 0;
    while (obs.size() < n && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("wait_obs", 32'(obs.size()), 32'(n));
  endtask

  task automatic clear_obs();
    obs.delete();
    obs_z.delete();
    obs_t.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int idx;
    int sent;
    logic acc_now;
    logic [W-1:0] bp_in[6];
    logic [W-1:0] bp_out[6];
    bp_in  = '{16'h0001, 16'h0002, 16'h8000, 16'h1234, 16'hFFFF, 16'h4000};
    bp_out = '{16'h0002, 16'h0004, 16'h0001, 16'h2468, 16'hFFFF, 16'h8000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(Out), 0);
    chk("rst_zero", 32'(out_zero), 0);
    rst_n = 1;
    #1;
    chk("rst_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // single op latency
    clear_obs();
    lat_en = 1;
    send(16'h1234, 4, 2'b00, w);
    wait_obs(1);
    chk("t1_out", 32'(obs[0]), 32'h2341);
    chk("t1_zero", 32'(obs_z[0]), 0);

    // back-to-back stream
    clear_obs();
    send(16'h00FF, 8, 2'b01, w);
    chk("b2b_rdy0", 32'(w), 0);
    send(16'h0001, 1, 2'b10, w);
    chk("b2b_rdy1", 32'(w), 0);
    send(16'h8000, 15, 2'b11, w);
    chk("b2b_rdy2", 32'(w), 0);
    send(16'h7FFF, 15, 2'b11, w);
    chk("b2b_rdy3", 32'(w), 0);
    wait_obs(4);
    chk("b2b_o0", 32'(obs[0]), 32'hFF00);
    chk("b2b_o1", 32'(obs[1]), 32'h8000);
    chk("b2b_o2", 32'(obs[2]), 32'hFFFF);
    chk("b2b_o3", 32'(obs[3]), 32'h0000);
    chk("b2b_z3", 32'(obs_z[3]), 1);
    for (int i = 1; i < 4; i++)
      chk("b2b_consec", 32'(obs_t[i] - obs_t[i-1]), 1);

    // backpressure
    clear_obs();
    lat_en = 0;
    out_ready = 0;
    idx = 0;
    for (int cy = 0; cy < 10; cy++) begin
      in_valid = idx < 6;
      In = bp_in[idx < 6 ? idx : 5];
      Cnt = 1;
      Op = 2'b00;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", 32'(idx), 4);
    chk("bp_ready", 32'(in_ready), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_hold", 32'(Out), 32'h0002);
    out_ready = 1;
    w = 0;
    while (idx < 6 && w < 50) begin
      in_valid = 1;
      In = bp_in[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
      w++;
    end
    in_valid = 0;
    wait_obs(6);
    for (int i = 0; i < 6; i++)
      chk("bp_out", 32'(obs[i]), 32'(bp_out[i]));

    // zero count passes through
    clear_obs();
    lat_en = 1;
    for (int o = 0; o < 4; o++) send(16'hA5C3, 0, 2'(o), w);
    wait_obs(4);
    for (int i = 0; i < 4; i++)
      chk("cnt0", 32'(obs[i]), 32'hA5C3);

    // reset mid-flight
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(16'h1111 << i, 3, 2'b00, w);
    @(posedge clk);
    #1;
    chk("rst_pre_valid", 32'(out_valid), 1);
    #1;
    rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_out", 32'(Out), 0);
    chk("arst_zero", 32'(out_zero), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    out_ready = 1;
    clear_obs();
    repeat (8) @(posedge clk);
    #1;
    chk("rst_stale", 32'(obs.size()), 0);
    chk("rst_ready2", 32'(in_ready), 1);
    send(16'h00F0, 4, 2'b10, w);
    wait_obs(1);
    chk("rst_new", 32'(obs[0]), 32'h000F);

    // random regression
    lat_en = 0;
    sent = 0;
    while (sent < 10000) begin
      out_ready = $urandom_range(0, 3) != 0;
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        In = W'($urandom);
        Cnt = CW'($urandom);
        Op = 2'($urandom);
        in_valid = 1;
      end
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (acc_now) sent++;
      @(posedge clk);
      #1;
      if (acc_now) in_valid = 0;
    end
    in_valid = 0;
    out_ready = 1;
    w = 0;
    while (eq.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain", 32'(eq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
